// File: rtl/multdiv_pkg.sv
// Shared multdiv definitions.
// FSM states, iteration constants and Booth pair codes.
package multdiv_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mstate_t;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration around the shared adder.
// Picks the adder operand and forms the shifted product.
module booth_step
  import multdiv_pkg::*;
(
  input  logic [32:0] lo_q,
  input  logic [31:0] m,
  input  logic [31:0] s,
  input  logic        ovf,
  output logic [31:0] b,
  output logic        cin,
  output logic [64:0] p_next
);

  logic [1:0] pair;

  assign pair = lo_q[1:0];

  always_comb begin
    b   = '0;
    cin = 1'b0;
    unique case (1'b1)
      (pair == BOOTH_ADD): b = m;
      (pair == BOOTH_SUB): begin
        b   = ~m;
        cin = 1'b1;
      end
      default: ;
    endcase
  end

  // true 33-bit sign keeps M = -2^31 exact
  assign p_next = {s[31] ^ ovf, s, lo_q[32:1]};

endmodule

// File: rtl/cla_add.sv
// 32-bit carry-lookahead adder.
// 4-bit lookahead groups, signed overflow flag.
module cla_add (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        overflow
);

  logic [31:0] g;
  logic [31:0] p;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    logic carry;
    logic c;
    logic c31;
    logic gg;
    logic pp;
    s     = '0;
    carry = cin;
    c     = 1'b0;
    c31   = 1'b0;
    gg    = 1'b0;
    pp    = 1'b0;
    for (int k = 0; k < 8; k++) begin
      gg = g[4*k+3]
         | (p[4*k+3] & g[4*k+2])
         | (p[4*k+3] & p[4*k+2] & g[4*k+1])
         | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pp = &p[4*k +: 4];
      c  = carry;
      for (int j = 0; j < 4; j++) begin
        s[4*k+j] = p[4*k+j] ^ c;
        if (4*k + j == 31) c31 = c;
        c = g[4*k+j] | (p[4*k+j] & c);
      end
      carry = gg | (pp & carry);
    end
    overflow = carry ^ c31;
  end

endmodule

// File: rtl/booth_mult_ctrl.sv
// Sequential signed 32x32 Booth multiplier.
// One shared adder, 32 iterations, low word plus overflow.
module booth_mult_ctrl
  import multdiv_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  mstate_t            state;
  mstate_t            state_n;
  logic [CNT_W-1:0]   cnt;
  logic [64:0]        p;
  logic [31:0]        m;
  logic [31:0]        add_b;
  logic               add_cin;
  logic [31:0]        add_s;
  logic               add_ovf;
  logic [64:0]        p_next;
  logic               last;

  assign last = (cnt == CNT_W'(ITER - 1));

  cla_add u_add (
    .a        (p[64:33]),
    .b        (add_b),
    .cin      (add_cin),
    .s        (add_s),
    .overflow (add_ovf)
  );

  booth_step u_step (
    .lo_q   (p[32:0]),
    .m      (m),
    .s      (add_s),
    .ovf    (add_ovf),
    .b      (add_b),
    .cin    (add_cin),
    .p_next (p_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      p              <= '0;
      m              <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (ctrl_MULT) begin
            m   <= data_operandA;
            p   <= {32'b0, data_operandB, 1'b0};
            cnt <= '0;
          end
        end
        RUN: begin
          p   <= p_next;
          cnt <= cnt + 1'b1;
          if (last) begin
            data_result    <= p_next[32:1];
            data_exception <= p_next[64:33] != {32{p_next[32]}};
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n        = state;
    data_resultRDY = 1'b0;
    busy           = 1'b0;
    unique case (state)
      IDLE: begin
        if (ctrl_MULT) state_n = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        busy           = 1'b1;
        data_resultRDY = 1'b1;
        state_n        = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Directed bench for booth_mult_ctrl.
// Hand-computed products, latency, busy/reset behaviour.
module tb_booth_mult_ctrl;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_chk;
  int n_fail;

  booth_mult_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic expect_eq(input string tag,
                           input logic [63:0] obs,
                           input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // pulse start on one edge, then scramble operands
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_rdy(output int lat, output bit seen);
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
    end
  endtask

  task automatic run(input string tag,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input logic exc);
    int lat;
    bit seen;
    start(a, b);
    wait_rdy(lat, seen);
    expect_eq({tag, "_rdy"}, 64'(seen), 64'd1);
    expect_eq({tag, "_lat"}, 64'(lat), 64'd32);
    expect_eq({tag, "_res"}, 64'(data_result), 64'(res));
    expect_eq({tag, "_exc"}, 64'(data_exception), 64'(exc));
    @(negedge clock);
    expect_eq({tag, "_rdy_off"}, 64'(data_resultRDY), 64'd0);
    expect_eq({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int  lat;
    bit  seen;
    int  pulses;
    bit  busy_ok;
    n_chk         = 0;
    n_fail        = 0;
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(negedge clock);
    expect_eq("rst_res", 64'(data_result), 64'd0);
    expect_eq("rst_exc", 64'(data_exception), 64'd0);
    expect_eq("rst_rdy", 64'(data_resultRDY), 64'd0);
    expect_eq("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;

    run("3x5",   32'd3,          32'd5,          32'h0000000F, 1'b0);
    expect_eq("hold_res", 64'(data_result), 64'h0F);
    run("m7x6",  32'hFFFFFFF9,   32'd6,          32'hFFFFFFD6, 1'b0);
    run("minx1", 32'h80000000,   32'd1,          32'h80000000, 1'b0);
    run("minxm1",32'h80000000,   32'hFFFFFFFF,   32'h80000000, 1'b1);
    run("big",   32'h00010000,   32'h00010000,   32'h00000000, 1'b1);
    run("minsq", 32'h80000000,   32'h80000000,   32'h00000000, 1'b1);

    // start while busy is ignored
    start(32'd2, 32'd9);
    pulses  = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      if (k == 10) begin
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd100;
      end else begin
        ctrl_MULT = 1'b0;
      end
      @(negedge clock);
      if (k <= 32 && !busy) busy_ok = 1'b0;
      if (data_resultRDY) begin
        pulses++;
        if (pulses == 1) begin
          expect_eq("ign_lat", 64'(k), 64'd32);
          expect_eq("ign_res", 64'(data_result), 64'h12);
        end
      end
    end
    ctrl_MULT = 1'b0;
    expect_eq("ign_busy", 64'(busy_ok), 64'd1);
    expect_eq("ign_pulses", 64'(pulses), 64'd1);
    expect_eq("ign_end_idle", 64'(busy), 64'd0);

    // abort mid-operation
    start(32'd4, 32'd4);
    repeat (14) @(negedge clock);
    expect_eq("abt_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    expect_eq("abt_res", 64'(data_result), 64'd0);
    expect_eq("abt_exc", 64'(data_exception), 64'd0);
    expect_eq("abt_busy0", 64'(busy), 64'd0);
    wait_rdy(lat, seen);
    expect_eq("abt_no_rdy", 64'(seen), 64'd0);
    run("after", 32'd4, 32'd4, 32'h00000010, 1'b0);

    // reset beats a simultaneous start
    @(negedge clock);
    reset         = 1'b1;
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd7;
    data_operandB = 32'd7;
    @(negedge clock);
    reset     = 1'b0;
    ctrl_MULT = 1'b0;
    expect_eq("rst_start_busy", 64'(busy), 64'd0);
    expect_eq("rst_start_res", 64'(data_result), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
